// File: rtl/spi_slave_engine_pkg.sv
//==============================================================================
// Module      : spi_slave_engine_pkg
// Description : Shared SPI mode encodings, FSM state codes and edge helper for
//               the SPI slave engine.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef SPI_slave_peripheral
`define SPI_slave_peripheral
`endif

package spi_slave_engine_pkg;

    // Mode encodings are {CPOL, CPHA}
    localparam logic [1:0] C_SPI_MODE0 = 2'b00;
    localparam logic [1:0] C_SPI_MODE1 = 2'b01;
    localparam logic [1:0] C_SPI_MODE2 = 2'b10;
    localparam logic [1:0] C_SPI_MODE3 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // True when MOSI is sampled on the rising SCK edge for the given mode.
    function automatic logic sample_on_rise(input logic [1:0] mode);
        case (mode)
            C_SPI_MODE0, C_SPI_MODE3: return 1'b1;
            C_SPI_MODE1, C_SPI_MODE2: return 1'b0;
            default:                  return 1'b1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_slave_engine_pin_sync.sv
//==============================================================================
// Module      : spi_pin_sync
// Description : Multi-stage input synchroniser with rise/fall edge detection.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_pin_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   dly_q;
    logic                   dly_d;
    logic                   w_level;

    generate
        if (SYNC_STAGES == 1) begin : g_single
            always_comb sync_d = async_in;
        end else begin : g_multi
            always_comb sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        end
    endgenerate

    always_comb begin
        w_level = sync_q[SYNC_STAGES-1];
        dly_d   = w_level;
        rise    = w_level & ~dly_q;
        fall    = ~w_level & dly_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            dly_q  <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_slave_engine.sv
//==============================================================================
// Module      : spi_slave_engine
// Description : Oversampled SPI slave with transmit holding register and
//               receive data register with overrun detection.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_slave_engine
    import spi_slave_engine_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SCK,
    input  logic                  MOSI,
    input  logic                  SS_n,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] txData,
    input  logic                  txLoad,
    output logic                  txReady,
    output logic [DATA_WIDTH-1:0] rxData,
    output logic                  rxFull,
    input  logic                  rxRead,
    output logic                  overrun,
    output logic                  busy
);

    localparam int               CNT_W      = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic                   miso_q, miso_d;
    logic [DATA_WIDTH-1:0]  tx_hold_q, tx_hold_d;
    logic                   tx_ready_q, tx_ready_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   rx_full_q, rx_full_d;
    logic                   overrun_q, overrun_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

    logic                   sck_rise, sck_fall, ss_rise, ss_fall;
    logic                   sample_edge, shift_edge;
    logic                   mosi_s;
    logic                   fetch;
    logic [DATA_WIDTH-1:0]  fetch_byte;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sck_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (SCK),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (SS_n),
        .rise     (ss_rise),
        .fall     (ss_fall)
    );

    // MOSI shares the SCK synchroniser depth so data and edge stay aligned.
    generate
        if (SYNC_STAGES == 1) begin : g_mosi_single
            always_comb mosi_sync_d = MOSI;
        end else begin : g_mosi_multi
            always_comb mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        end
    endgenerate

    always_comb begin
        mosi_s     = mosi_sync_q[SYNC_STAGES-1];
        fetch_byte = tx_ready_q ? '0 : tx_hold_q;
        if (sample_on_rise({CPOL, CPHA})) begin
            sample_edge = sck_rise;
            shift_edge  = sck_fall;
        end else begin
            sample_edge = sck_fall;
            shift_edge  = sck_rise;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        miso_d    = miso_q;
        rx_data_d = rx_data_q;
        rx_full_d = rx_full_q;
        overrun_d = overrun_q;
        fetch     = 1'b0;

        if (rxRead) begin
            rx_full_d = 1'b0;
            overrun_d = 1'b0;
        end

        if (ss_rise && (state_q != ST_DONE)) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                    if (ss_fall) begin
                        state_d = ST_ACTIVE;
                        if (!CPHA) begin
                            fetch   = 1'b1;
                            shift_d = fetch_byte;
                            miso_d  = fetch_byte[DATA_WIDTH-1];
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (sample_edge) begin
                        shift_d   = {shift_q[DATA_WIDTH-2:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == C_LAST_BIT) begin
                            state_d = ST_DONE;
                        end
                    end else if (shift_edge) begin
                        if (CPHA && (bit_cnt_q == '0)) begin
                            fetch   = 1'b1;
                            shift_d = fetch_byte;
                            miso_d  = fetch_byte[DATA_WIDTH-1];
                        end else begin
                            miso_d = shift_q[DATA_WIDTH-1];
                        end
                    end
                end
                ST_DONE: begin
                    bit_cnt_d = '0;
                    rx_data_d = shift_q;
                    rx_full_d = 1'b1;
                    // A simultaneous read consumes the old byte, so no overrun.
                    if (!rxRead && rx_full_q) begin
                        overrun_d = 1'b1;
                    end
                    if (ss_rise) begin
                        state_d = ST_IDLE;
                        miso_d  = 1'b0;
                    end else begin
                        state_d = ST_ACTIVE;
                        if (!CPHA) begin
                            fetch   = 1'b1;
                            shift_d = fetch_byte;
                            miso_d  = fetch_byte[DATA_WIDTH-1];
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_hold_d  = tx_hold_q;
        tx_ready_d = tx_ready_q;
        if (fetch) begin
            tx_ready_d = 1'b1;
        end
        if (txLoad && tx_ready_q) begin
            tx_hold_d  = txData;
            tx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            miso_q      <= 1'b0;
            tx_hold_q   <= '0;
            tx_ready_q  <= 1'b1;
            rx_data_q   <= '0;
            rx_full_q   <= 1'b0;
            overrun_q   <= 1'b0;
            mosi_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            miso_q      <= miso_d;
            tx_hold_q   <= tx_hold_d;
            tx_ready_q  <= tx_ready_d;
            rx_data_q   <= rx_data_d;
            rx_full_q   <= rx_full_d;
            overrun_q   <= overrun_d;
            mosi_sync_q <= mosi_sync_d;
        end
    end

    always_comb begin
        MISO    = miso_q;
        txReady = tx_ready_q;
        rxData  = rx_data_q;
        rxFull  = rx_full_q;
        overrun = overrun_q;
        busy    = (state_q != ST_IDLE);
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_engine.sv
//==============================================================================
// Module      : tb_spi_slave_engine
// Description : Scoreboard bench for spi_slave_engine in mode 0 and mode 3.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_spi_slave_engine;

    localparam int HALF = 4;   // SCK half period in clk cycles (SCK = clk/8)
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst     [2] = '{1'b1, 1'b1};
    logic       sck     [2] = '{1'b0, 1'b1};
    logic       mosi    [2] = '{1'b0, 1'b0};
    logic       ss_n    [2] = '{1'b1, 1'b1};
    logic [7:0] tx_data [2] = '{8'h00, 8'h00};
    logic       tx_load [2] = '{1'b0, 1'b0};
    logic       rd_man  [2] = '{1'b0, 1'b0};
    logic       rd_auto [2] = '{1'b0, 1'b0};
    logic       rx_read [2];
    logic       miso    [2];
    logic       tx_ready[2];
    logic [7:0] rx_data [2];
    logic       rx_full [2];
    logic       ovr     [2];
    logic       busy    [2];

    int n_checks = 0;
    int n_errors = 0;
    bit auto_read = 1'b1;
    int cyc = 0;
    int last_sample_cyc [2] = '{0, 0};
    logic prev_full [2] = '{1'b0, 1'b0};

    // Reference model: holding-register contents per target, expected rx bytes.
    bit         hv [2] = '{1'b0, 1'b0};
    logic [7:0] hb [2] = '{8'h00, 8'h00};
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rx_read[0] = rd_auto[0] | rd_man[0];
    assign rx_read[1] = rd_auto[1] | rd_man[1];

    spi_slave_engine #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(SYNC)) dut0 (
        .clk(clk), .reset(rst[0]), .SCK(sck[0]), .MOSI(mosi[0]), .SS_n(ss_n[0]),
        .MISO(miso[0]), .txData(tx_data[0]), .txLoad(tx_load[0]), .txReady(tx_ready[0]),
        .rxData(rx_data[0]), .rxFull(rx_full[0]), .rxRead(rx_read[0]),
        .overrun(ovr[0]), .busy(busy[0])
    );

    spi_slave_engine #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(SYNC)) dut1 (
        .clk(clk), .reset(rst[1]), .SCK(sck[1]), .MOSI(mosi[1]), .SS_n(ss_n[1]),
        .MISO(miso[1]), .txData(tx_data[1]), .txLoad(tx_load[1]), .txReady(tx_ready[1]),
        .rxData(rx_data[1]), .rxFull(rx_full[1]), .rxRead(rx_read[1]),
        .overrun(ovr[1]), .busy(busy[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] fetch(input int t);
        logic [7:0] r;
        r     = hv[t] ? hb[t] : 8'h00;
        hv[t] = 1'b0;
        return r;
    endfunction

    function automatic void push_exp(input int t, input logic [7:0] d);
        if (t == 0) exp0.push_back(d);
        else        exp1.push_back(d);
    endfunction

    // Monitor: every rising rxFull must deliver the oldest expected byte.
    always @(negedge clk) begin
        for (int t = 0; t < 2; t++) begin
            logic [7:0] e;
            bit         have;
            rd_auto[t] = 1'b0;
            if (rx_full[t] && !prev_full[t]) begin
                have = (t == 0) ? (exp0.size() != 0) : (exp1.size() != 0);
                if (!have) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rx_unexpected[%0d]: actual=0x%0h required=none", t, rx_data[t]);
                end else begin
                    e = (t == 0) ? exp0.pop_front() : exp1.pop_front();
                    chk($sformatf("rx_data[%0d]", t), rx_data[t], e);
                    chk($sformatf("rx_latency[%0d]", t), cyc - last_sample_cyc[t], SYNC + 2);
                end
                if (auto_read) rd_auto[t] = 1'b1;
            end
            prev_full[t] = rx_full[t];
        end
    end

    task automatic tx_load_t(input int t, input logic [7:0] d);
        @(negedge clk);
        tx_data[t] = d;
        tx_load[t] = 1'b1;
        if (!hv[t]) begin
            hv[t] = 1'b1;
            hb[t] = d;
        end
        @(negedge clk);
        tx_load[t] = 1'b0;
    endtask

    task automatic ss_assert(input int t);
        @(negedge clk);
        ss_n[t] = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic ss_release(input int t);
        @(negedge clk);
        sck[t] = (t == 1);
        repeat (HALF) @(negedge clk);
        ss_n[t] = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    // Both modes drive data on the falling edge and sample on the rising edge.
    task automatic spi_byte(input int t, input logic [7:0] d, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            sck[t]  = 1'b0;
            mosi[t] = d[7-i];
            repeat (HALF) @(negedge clk);
            sck[t] = 1'b1;
            got = {got[6:0], miso[t]};
            last_sample_cyc[t] = cyc;
            repeat (HALF - 1) @(negedge clk);
        end
    endtask

    task automatic xfer(input int t, input logic [7:0] d, input bit push);
        logic [7:0] e, got;
        ss_assert(t);
        e = fetch(t);
        if (push) push_exp(t, d);
        spi_byte(t, d, 8, got);
        if (t == 0) void'(fetch(0));
        ss_release(t);
        chk($sformatf("miso_byte[%0d]", t), got, e);
        chk($sformatf("tx_ready[%0d]", t), tx_ready[t], !hv[t]);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] e1, e2, g1, g2, r;
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        repeat (4) @(negedge clk);
        for (int t = 0; t < 2; t++) begin
            chk("reset_miso", miso[t], 0);
            chk("reset_tx_ready", tx_ready[t], 1);
            chk("reset_rx_data", rx_data[t], 0);
            chk("reset_rx_full", rx_full[t], 0);
            chk("reset_overrun", ovr[t], 0);
            chk("reset_busy", busy[t], 0);
        end

        // Mode 0 basic byte with a loaded transmit byte, then with none.
        tx_load_t(0, 8'hA5);
        chk("tx_ready_after_load", tx_ready[0], 0);
        xfer(0, 8'h3C, 1'b1);
        chk("rx_data_hold", rx_data[0], 8'h3C);
        xfer(0, 8'hFF, 1'b1);

        // Overrun: two bytes with no reads, then a single read clears both flags.
        auto_read = 1'b0;
        xfer(0, 8'h11, 1'b1);
        xfer(0, 8'h22, 1'b0);
        chk("overrun_set", ovr[0], 1);
        chk("overrun_full", rx_full[0], 1);
        chk("overrun_data", rx_data[0], 8'h22);
        rd_man[0] = 1'b1;
        @(negedge clk);
        rd_man[0] = 1'b0;
        chk("read_clears_full", rx_full[0], 0);
        chk("read_clears_overrun", ovr[0], 0);
        auto_read = 1'b1;
        repeat (2) @(negedge clk);

        // Abort after 5 bits, then a full byte.
        ss_assert(0);
        void'(fetch(0));
        spi_byte(0, 8'hF0, 5, g1);
        ss_release(0);
        chk("abort_rx_full", rx_full[0], 0);
        chk("abort_busy", busy[0], 0);
        chk("abort_bit_cnt", dut0.bit_cnt_q, 0);
        xfer(0, 8'h12, 1'b1);

        // Mode 0 burst; a load while the holding register is full is dropped.
        ss_assert(0);
        e1 = fetch(0);
        tx_load_t(0, 8'h5A);
        push_exp(0, 8'hC3);
        fork
            spi_byte(0, 8'hC3, 8, g1);
            begin
                repeat (12) @(negedge clk);
                tx_load_t(0, 8'h99);
            end
        join
        e2 = fetch(0);
        push_exp(0, 8'h96);
        spi_byte(0, 8'h96, 8, g2);
        void'(fetch(0));
        ss_release(0);
        chk("burst_miso_0", g1, e1);
        chk("burst_miso_1", g2, e2);
        chk("burst_tx_ready", tx_ready[0], 1);

        // Mode 3 back-to-back bytes, holding register reloaded between them.
        tx_load_t(1, 8'hC6);
        ss_assert(1);
        e1 = fetch(1);
        push_exp(1, 8'h81);
        spi_byte(1, 8'h81, 8, g1);
        tx_load_t(1, 8'h55);
        e2 = fetch(1);
        push_exp(1, 8'h7E);
        spi_byte(1, 8'h7E, 8, g2);
        ss_release(1);
        chk("m3_miso_0", g1, e1);
        chk("m3_miso_1", g2, e2);
        chk("m3_rx_last", rx_data[1], 8'h7E);

        // Randomised single-byte transfers on both modes.
        for (int i = 0; i < 20; i++) begin
            int t;
            t = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) tx_load_t(t, 8'($urandom));
            if ($urandom_range(0, 3) == 0) tx_load_t(t, 8'($urandom));
            r = 8'($urandom);
            xfer(t, r, 1'b1);
        end

        // Reset in the middle of bit 4 of a mode 0 byte.
        tx_load_t(0, 8'h3C);
        ss_assert(0);
        void'(fetch(0));
        tx_load_t(0, 8'hE7);
        fork
            spi_byte(0, 8'hA5, 8, g1);
            begin
                repeat (4 * 2 * HALF - 2) @(negedge clk);
                rst[0] = 1'b1;
                @(negedge clk);
                rst[0] = 1'b0;
                hv[0] = 1'b0;
                chk("midreset_miso", miso[0], 0);
                chk("midreset_tx_ready", tx_ready[0], 1);
                chk("midreset_rx_data", rx_data[0], 0);
                chk("midreset_rx_full", rx_full[0], 0);
                chk("midreset_overrun", ovr[0], 0);
                chk("midreset_busy", busy[0], 0);
            end
        join
        ss_release(0);
        xfer(0, 8'h5C, 1'b1);

        repeat (4 * HALF) @(negedge clk);
        chk("queue0_drained", exp0.size(), 0);
        chk("queue1_drained", exp1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_slave_engine.md
Name: spi_slave_engine

Overview:
- SPI responder (slave) that talks to an external SPI master over SCK/MOSI/MISO/SS_n.
- The processor core loads a transmit byte into it and reads received bytes from it.
- Sits alongside the existing SPI master peripheral, on the opposite end of the same serial protocol.
- Fully synchronous to clk: external pins are oversampled; clk must be at least 4x the SCK frequency.

Parameters:
- DATA_WIDTH, 8, shift length in bits; transfers are MSB first.
- CPOL, 0, idle level of SCK.
- CPHA, 0: sample on the leading edge. 1: sample on the trailing edge.
- SYNC_STAGES, 2, flip-flop depth of the SCK/MOSI/SS_n synchronisers.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- SCK  in  1  serial clock from the master (asynchronous)
- MOSI  in  1  serial data from the master (asynchronous)
- SS_n  in  1  active-low slave select (asynchronous)
- MISO  out  1  serial data to the master
- txData  in  DATA_WIDTH  byte to transmit
- txLoad  in  1  write strobe for txData
- txReady  out  1  transmit holding register is empty
- rxData  out  DATA_WIDTH  last received byte
- rxFull  out  1  rxData holds an unread byte
- rxRead  in  1  core has consumed rxData
- overrun  out  1  sticky flag: a byte completed while rxFull=1
- busy  out  1  SS_n is asserted and a transfer is in progress

Behaviour:
- Reset values: MISO=0, txReady=1, rxData=0, rxFull=0, overrun=0, busy=0, state=IDLE, bit counter=0, shift register=0.
- Inputs pass through SYNC_STAGES flip-flops. Edges are detected by comparing the last synchroniser stage with a delayed copy.
- Leading edge = SCK rising if CPOL=0, falling if CPOL=1. Sample edge = leading edge if CPHA=0, else trailing edge. Shift edge = the other edge.
- Transmit holding register:
  - txLoad with txReady=1 captures txData and clears txReady.
  - txLoad with txReady=0 is ignored; the held byte is unchanged.
  - txReady sets again when the held byte moves into the shift register.
- States:
  - IDLE: SS_n falling goes to ACTIVE. If CPHA=0, the shift register loads from the holding register (0x00 if empty) on entry, so the MSB is on MISO before the first edge.
  - ACTIVE:
    - Sample edge: shift in MOSI at the LSB and increment the bit counter.
    - Shift edge: shift out, MISO = next MSB.
    - CPHA=1: the first shift edge of each byte loads the holding register instead of shifting.
    - Bit counter reaching DATA_WIDTH: go to DONE.
  - DONE (one clk): transfer the byte to rxData, clear the bit counter, return to ACTIVE.
    - rxFull was 0: set rxFull.
    - rxFull was already 1: rxData is still overwritten, rxFull stays 1, overrun sets.
    - CPHA=0 only: the holding register (or 0x00) loads into the shift register at DONE for the next byte.
  - SS_n rising in any state: go to IDLE on the next clk. A partial byte is discarded; rxFull and rxData are unchanged and the bit counter clears. An unconsumed holding byte is kept.
- MISO is driven 0 in IDLE. The pin has no tristate; an external buffer handles that.
- rxRead clears rxFull and overrun on the next clk. rxRead in the same cycle as DONE: the new byte wins, rxFull stays 1, overrun is not set.
- Latency: rxFull rises SYNC_STAGES+2 clks after the 8th external sample edge.
- busy = (state != IDLE).
- Reset mid-transfer returns every register to its reset value, regardless of SS_n.

Decomposition:
- Shared defines file (existing `defines.v` style):
  - SPI mode encodings.
  - State codes IDLE/ACTIVE/DONE.
  - The `SPI_slave_peripheral` enable macro for the top-level include.
- One natural sub-module, spi_pin_sync: SYNC_STAGES synchroniser plus rise/fall edge detector, instantiated once each for SCK and SS_n. MOSI uses synchronisation only.

Test Plan:
- Mode 0, txLoad 0xA5, master sends 0x3C with SCK = clk/8 -> MISO bits 1,0,1,0,0,1,0,1; rxData=0x3C; rxFull=1; txReady returns to 1.
- Mode 3 (CPOL=1, CPHA=1), two back-to-back bytes 0x81,0x7E with SS_n held low, holding reloaded with 0x55 between them -> rxData sequence 0x81 then 0x7E; second MISO byte = 0x55.
- No txLoad, master sends 0xFF -> MISO all zeros; rxData=0xFF.
- Two bytes received without rxRead -> overrun=1, rxData=second byte; rxRead -> rxFull=0 and overrun=0 on the next clk.
- SS_n deasserted after 5 bits of 0xF0 -> rxFull stays 0, busy drops, bit counter 0; the next full byte 0x12 is received correctly.
- reset asserted mid-byte (bit 4) -> all outputs at reset values the next clk; txLoad with txReady=0 during a transfer leaves the held byte unchanged.
